// File: rtl/full_adder_cell.sv
// full_adder_cell: 1-bit full adder bit cell for ripple-carry chains.
// Combinational sum/cout/p/g settle without a clock so long chains ripple
// freely; sum_q/cout_q are an optional pipelined copy with enable and
// synchronous active-high reset.
module full_adder_cell (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic en,
  output logic sum,
  output logic cout,
  output logic p,
  output logic g,
  output logic sum_q,
  output logic cout_q
);

  logic w_p;
  logic w_g;
  logic w_sum;
  logic w_cout;
  logic r_sum_q;
  logic r_cout_q;

  // Propagate/generate form so cout is also usable by lookahead logic.
  always_comb begin
    w_p    = a ^ b;
    w_g    = a & b;
    w_sum  = w_p ^ cin;
    w_cout = w_g | (w_p & cin);
  end

  // Pipelined copy: reset wins over enable, otherwise capture or hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum_q  <= 1'b0;
      r_cout_q <= 1'b0;
    end else if (en) begin
      r_sum_q  <= w_sum;
      r_cout_q <= w_cout;
    end
  end

  assign sum    = w_sum;
  assign cout   = w_cout;
  assign p      = w_p;
  assign g      = w_g;
  assign sum_q  = r_sum_q;
  assign cout_q = r_cout_q;

endmodule

// File: tb/tb_full_adder_cell.sv
// Bench for full_adder_cell: truth table, a 64-cell ripple chain against
// 64-bit arithmetic, and the registered path against a small model.
module tb_full_adder_cell;

  logic clk = 1'b0;
  logic reset, a, b, cin, en;
  logic sum, cout, p, g, sum_q, cout_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  full_adder_cell u_dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .cin(cin), .en(en),
    .sum(sum), .cout(cout), .p(p), .g(g), .sum_q(sum_q), .cout_q(cout_q)
  );

  // 64-cell ripple chain
  logic [63:0] op_a, op_b;
  logic [63:0] ch_sum, ch_cout, ch_p, ch_g, ch_sq, ch_cq;
  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_chain
      full_adder_cell u_cell (
        .clk(clk), .reset(reset), .a(op_a[gi]), .b(op_b[gi]),
        .cin((gi == 0) ? 1'b0 : ch_cout[(gi == 0) ? 0 : gi - 1]),
        .en(1'b0),
        .sum(ch_sum[gi]), .cout(ch_cout[gi]), .p(ch_p[gi]), .g(ch_g[gi]),
        .sum_q(ch_sq[gi]), .cout_q(ch_cq[gi])
      );
    end
  endgenerate

  // Registered-path model state
  logic m_sq, m_cq;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check combinational outputs of the single cell against counting rules.
  task automatic chk_comb(input string tag);
    int n;
    n = int'(a) + int'(b) + int'(cin);
    chk1({tag, "_sum"},  sum,  logic'(n % 2));
    chk1({tag, "_cout"}, cout, logic'(n >= 2));
    chk1({tag, "_p"},    p,    logic'((int'(a) + int'(b)) == 1));
    chk1({tag, "_g"},    g,    logic'((int'(a) + int'(b)) == 2));
  endtask

  // One clock edge, updating the model with the values present at the edge.
  task automatic edge_step();
    int n;
    n = int'(a) + int'(b) + int'(cin);
    @(posedge clk);
    if (reset) begin
      m_sq = 1'b0; m_cq = 1'b0;
    end else if (en) begin
      m_sq = logic'(n % 2); m_cq = logic'(n >= 2);
    end
    #1;
  endtask

  task automatic chk_reg(input string tag);
    chk1({tag, "_sum_q"},  sum_q,  m_sq);
    chk1({tag, "_cout_q"}, cout_q, m_cq);
  endtask

  task automatic chain(input string tag, input logic [63:0] x, input logic [63:0] y);
    logic [64:0] full;
    op_a = x; op_b = y;
    #1;
    full = {1'b0, x} + {1'b0, y};
    chk64({tag, "_sum"}, ch_sum, full[63:0]);
    chk1({tag, "_cout"}, ch_cout[63], full[64]);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0;
    op_a = '0; op_b = '0;
    m_sq = 1'b0; m_cq = 1'b0;

    // Truth table with clock idle relative to checks
    for (int i = 0; i < 8; i++) begin
      {a, b, cin} = 3'(i);
      #1;
      chk_comb($sformatf("tt%0d", i));
    end
    a = 1; b = 1; cin = 1; #1;
    chk1("tt111_sum", sum, 1'b1); chk1("tt111_cout", cout, 1'b1);
    a = 1; b = 0; cin = 0; #1;
    chk1("tt100_sum", sum, 1'b1); chk1("tt100_cout", cout, 1'b0);
    a = 1; b = 1; cin = 0; #1;
    chk1("pg11_p", p, 1'b0); chk1("pg11_g", g, 1'b1);

    // Ripple chain
    chain("ch_ones_plus1", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    chk64("ch_ones_plus1_lit", ch_sum, 64'h0);
    chk1("ch_ones_plus1_cout_lit", ch_cout[63], 1'b1);
    chain("ch_msb", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_4AB3);
    chk64("ch_msb_lit", ch_sum, 64'h7FFF_FFFF_FFFF_4AB3);
    chain("ch_twos", 64'h2DAB_324F_789F_34FF, ~64'h2DAB_324F_789F_34FF + 64'h1);
    chk64("ch_twos_lit", ch_sum, 64'h0);
    chain("ch_zero", 64'h0, 64'h0);
    for (int i = 0; i < 100; i++)
      chain($sformatf("ch_rand%0d", i), {$urandom, $urandom}, {$urandom, $urandom});

    // Registered path: reset
    reset = 1; en = 0; a = 1; b = 1; cin = 1;
    edge_step();
    chk1("rst_sum_q", sum_q, 1'b0); chk1("rst_cout_q", cout_q, 1'b0);
    chk_comb("comb_in_reset");

    // Capture 1+1+0
    reset = 0; en = 1; a = 1; b = 1; cin = 0;
    edge_step();
    chk1("cap_sum_q", sum_q, 1'b0); chk1("cap_cout_q", cout_q, 1'b1);

    // Hold over 3 edges
    en = 0; a = 1; b = 0; cin = 0;
    #1;
    chk1("hold_comb_sum", sum, 1'b1); chk1("hold_comb_cout", cout, 1'b0);
    for (int i = 0; i < 3; i++) begin
      edge_step();
      chk1($sformatf("hold%0d_sum_q", i), sum_q, 1'b0);
      chk1($sformatf("hold%0d_cout_q", i), cout_q, 1'b1);
    end

    // Reset priority over enable
    reset = 1; en = 1; a = 1; b = 1; cin = 1;
    #1;
    chk1("prio_pre_sum", sum, 1'b1); chk1("prio_pre_cout", cout, 1'b1);
    edge_step();
    chk1("prio_sum_q", sum_q, 1'b0); chk1("prio_cout_q", cout_q, 1'b0);
    chk1("prio_post_sum", sum, 1'b1); chk1("prio_post_cout", cout, 1'b1);

    // After release with en=0, still cleared; then first capture
    reset = 0; en = 0;
    edge_step();
    chk_reg("rel_hold");
    en = 1;
    edge_step();
    chk1("rel_cap_sum_q", sum_q, 1'b1); chk1("rel_cap_cout_q", cout_q, 1'b1);

    // Random registered traffic
    for (int i = 0; i < 200; i++) begin
      reset = ($urandom_range(0, 9) == 0);
      en    = 1'($urandom);
      a     = 1'($urandom);
      b     = 1'($urandom);
      cin   = 1'($urandom);
      #1;
      chk_comb($sformatf("rnd%0d", i));
      edge_step();
      chk_reg($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
